apb_cmd_master: RTL and testbench

Upstream APB4 requester that turns a simple valid/ready command stream into single APB transfers on the apb_if signal set, then returns one response per command on a valid/ready response stream. It drives the bus that the APB FIFO/register slave consumes. The bus interface is the bench-driven side in UVM and this block in the integrated design. It adds a PREADY wait-state timeout so a hung slave cannot stall the requester.

---
 rtl/apb_cmd_master.sv | 166 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB4 requester: one command in, one SETUP/ACCESS transfer, one response out.
// Zero-wait PREADY gives rsp_valid three cycles after the command handshake; rsp_ready low holds RESP and blocks cmd_ready.
module apb_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [2:0]          PPROT,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [2:0]          pprot_q, pprot_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                tout_q, tout_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                to_hit;

  // The limit is reached on the TIMEOUT-th wait cycle; PREADY on that cycle still wins.
  assign to_hit = (TIMEOUT != 0) && !PREADY && (cnt_q == TO_LIM - 16'd1);

  assign cmd_ready   = (state_q == IDLE) && !PRESET;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tout_q;
  assign PADDR       = paddr_q;
  assign PPROT       = pprot_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pprot_d   = pprot_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    tout_d    = tout_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : '0;
          pprot_d  = cmd_prot;
          psel_d   = 1'b1;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d   = pwrite_q ? '0 : PRDATA;
          err_d     = PSLVERR;
          tout_d    = 1'b0;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (to_hit) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            tout_d    = 1'b1;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pprot_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pprot_q   <= pprot_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tout_q    <= tout_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed pins plus randomized commands against a timeline model.
// A second instance with the timeout disabled checks that a stuck slave holds the bus.
module tb_apb_cmd_master;

  localparam int TO = 4;
  localparam int N  = 200;

  logic        PCLK;
  logic        PRESET, cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [2:0]  PPROT;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [3:0]  PSTRB;

  logic        h_rst, h_cmd_valid, h_cmd_ready, h_rsp_valid, h_rsp_err, h_rsp_timeout;
  logic [31:0] h_rsp_rdata, h_paddr, h_pwdata, h_prdata;
  logic [2:0]  h_pprot;
  logic        h_psel, h_penable, h_pwrite, h_pready, h_pslverr;
  logic [3:0]  h_pstrb;

  int tests_run = 0;
  int tests_failed = 0;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_hang (
    .PCLK(PCLK), .PRESET(h_rst),
    .cmd_valid(h_cmd_valid), .cmd_ready(h_cmd_ready), .cmd_write(1'b0),
    .cmd_addr(32'h40), .cmd_wdata(32'h0), .cmd_strb(4'h0), .cmd_prot(3'h0),
    .rsp_valid(h_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(h_rsp_rdata),
    .rsp_err(h_rsp_err), .rsp_timeout(h_rsp_timeout),
    .PADDR(h_paddr), .PPROT(h_pprot), .PSEL(h_psel), .PENABLE(h_penable), .PWRITE(h_pwrite),
    .PWDATA(h_pwdata), .PSTRB(h_pstrb), .PREADY(h_pready), .PRDATA(h_prdata), .PSLVERR(h_pslverr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Timeline model: a command accepted in cycle T is SETUP at T+1, ACCESS for alen cycles, then RESP.
  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_busy = 0, m_to = 0, accepted = 0;
  int          m_tacc = 0, m_alen = 0, a_w = 0;
  logic [31:0] a_rdata = '0;
  bit          a_err = 0;
  int          p_w = 0;
  logic [31:0] p_rdata = '0;
  bit          p_err = 0;
  logic [31:0] e_paddr = '0, e_pwdata = '0;
  logic [3:0]  e_pstrb = '0;
  logic [2:0]  e_pprot = '0;
  logic        e_pwrite = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // 0 idle, 1 setup, 2 access, 3 response
  function automatic int phase(input int c);
    int d;
    if (!m_busy) return 0;
    d = c - m_tacc;
    if (d == 1) return 1;
    if (d <= 1 + m_alen) return 2;
    return 3;
  endfunction

  task automatic model_edge();
    int ph;
    ph = phase(cyc);
    accepted = 0;
    if (PRESET) begin
      m_busy = 0;
      e_paddr = '0; e_pwdata = '0; e_pstrb = '0; e_pprot = '0; e_pwrite = 0;
    end else if (!m_busy && cmd_valid) begin
      m_busy = 1; m_tacc = cyc; accepted = 1;
      e_paddr = cmd_addr; e_pwrite = cmd_write; e_pwdata = cmd_wdata;
      e_pstrb = cmd_write ? cmd_strb : 4'h0; e_pprot = cmd_prot;
      a_w = p_w; a_rdata = p_rdata; a_err = p_err;
      m_to = (TO != 0) && (p_w >= TO);
      m_alen = m_to ? TO : p_w + 1;
    end else if (ph == 3 && rsp_ready) begin
      m_busy = 0;
    end
    cyc++;
  endtask

  // Slave side: ready on the (a_w+1)-th ACCESS cycle, junk on every other cycle.
  task automatic drive_slave();
    if (phase(cyc) == 2 && (cyc - m_tacc - 2) == a_w) begin
      PREADY = 1'b1; PRDATA = a_rdata; PSLVERR = a_err;
    end else begin
      PREADY = (phase(cyc) == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    model_edge();
    #1;
    drive_slave();
  endtask

  task automatic gen_cmd();
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom_range(0, 15));
    cmd_prot  = 3'($urandom_range(0, 7));
    p_w       = ($urandom_range(0, 9) < 2) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
    p_rdata   = $urandom;
    p_err     = ($urandom_range(0, 3) == 0);
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("cmd_ready", cmd_ready, (!m_busy && !PRESET));
      chk("psel", PSEL, (phase(cyc) == 1 || phase(cyc) == 2));
      chk("penable", PENABLE, (phase(cyc) == 2));
      chk("rsp_valid", rsp_valid, (phase(cyc) == 3));
      chk("paddr", PADDR, e_paddr);
      chk("pwrite", PWRITE, e_pwrite);
      chk("pwdata", PWDATA, e_pwdata);
      chk("pstrb", PSTRB, e_pstrb);
      chk("pprot", PPROT, e_pprot);
      if (phase(cyc) == 3) begin
        chk("rsp_rdata", rsp_rdata, (m_to || e_pwrite) ? 32'h0 : a_rdata);
        chk("rsp_err", rsp_err, (m_to || a_err));
        chk("rsp_timeout", rsp_timeout, m_to);
      end
    end
  end

  // Timeout-disabled instance: PREADY stuck low must hold the transfer indefinitely.
  bit h_done = 0;
  int h_rsp_cnt = 0;
  initial begin
    h_rst = 1'b1; h_cmd_valid = 1'b0; h_pready = 1'b0; h_prdata = '0; h_pslverr = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 h_rst = 1'b0; h_cmd_valid = 1'b1;
    @(posedge PCLK);
    #1 h_cmd_valid = 1'b0;
    repeat (1100) begin
      @(negedge PCLK);
      if (h_rsp_valid) h_rsp_cnt++;
      h_prdata = $urandom; h_pslverr = 1'($urandom_range(0, 1));
    end
    chk("hang_no_rsp", h_rsp_cnt, 0);
    chk("hang_psel", h_psel, 1);
    chk("hang_penable", h_penable, 1);
    @(posedge PCLK);
    #1 h_rst = 1'b1;
    @(posedge PCLK);
    #1 h_rst = 1'b0;
    @(negedge PCLK);
    chk("hang_rst_psel", h_psel, 0);
    chk("hang_rst_ready", h_cmd_ready, 1);
    h_done = 1;
  end

  initial begin
    int k, gap;
    bit rst_plan, preload;
    PRESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    tick();
    chk_en = 1;
    tick();
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", PSEL, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);

    // Zero-wait write
    cmd_write = 1; cmd_addr = 32'h10; cmd_wdata = 32'hA5A5_0001; cmd_strb = 4'hF; cmd_prot = 3'h2;
    p_w = 0; p_err = 0; p_rdata = 32'hDEAD_BEEF; cmd_valid = 1; rsp_ready = 1;
    tick(); cmd_valid = 0;
    @(negedge PCLK); chk("wr_t1_psel", PSEL, 1); chk("wr_t1_penable", PENABLE, 0); chk("wr_paddr", PADDR, 32'h10);
    tick();
    @(negedge PCLK); chk("wr_t2_penable", PENABLE, 1); chk("wr_pwdata", PWDATA, 32'hA5A5_0001); chk("wr_pstrb", PSTRB, 4'hF);
    tick();
    @(negedge PCLK); chk("wr_t3_rsp_valid", rsp_valid, 1); chk("wr_rdata", rsp_rdata, 0); chk("wr_err", rsp_err, 0);
    tick();

    // Read with 3 wait states, then 5 cycles of response backpressure with a write queued behind it
    cmd_write = 0; cmd_addr = 32'h04; cmd_strb = 4'hF; p_w = 3; p_rdata = 32'h1234_5678; p_err = 0;
    cmd_valid = 1; rsp_ready = 0;
    tick(); cmd_valid = 0;
    tick();
    @(negedge PCLK); chk("rd_pstrb", PSTRB, 0); chk("rd_penable", PENABLE, 1);
    repeat (3) tick();
    @(negedge PCLK); chk("rd_t5_penable", PENABLE, 1);
    tick();
    @(negedge PCLK); chk("rd_t6_rsp_valid", rsp_valid, 1); chk("rd_rdata", rsp_rdata, 32'h1234_5678);
    cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h5555_AAAA; p_w = 0; p_err = 1; cmd_valid = 1;
    repeat (4) tick();
    @(negedge PCLK); chk("bp_cmd_ready", cmd_ready, 0); chk("bp_psel", PSEL, 0); chk("bp_rdata", rsp_rdata, 32'h1234_5678);
    tick(); rsp_ready = 1;
    tick();
    @(negedge PCLK); chk("bp_next_ready", cmd_ready, 1); chk("bp_rsp_done", rsp_valid, 0);
    tick(); cmd_valid = 0;
    @(negedge PCLK); chk("bp_next_psel", PSEL, 1);
    repeat (2) tick();
    @(negedge PCLK); chk("slverr_err", rsp_err, 1); chk("slverr_to", rsp_timeout, 0); chk("slverr_vld", rsp_valid, 1);
    tick();

    // Timeout after exactly TO ACCESS cycles
    cmd_write = 0; cmd_addr = 32'h08; p_w = 9; p_rdata = 32'hFFFF_0000; p_err = 0; cmd_valid = 1;
    tick(); cmd_valid = 0;
    repeat (4) tick();
    @(negedge PCLK); chk("to_last_access", PENABLE, 1);
    tick();
    @(negedge PCLK);
    chk("to_rsp_valid", rsp_valid, 1); chk("to_timeout", rsp_timeout, 1);
    chk("to_err", rsp_err, 1); chk("to_rdata", rsp_rdata, 0); chk("to_psel", PSEL, 0);
    tick();

    // Reset during ACCESS wait states
    cmd_write = 0; cmd_addr = 32'h0C; p_w = 3; cmd_valid = 1;
    tick(); cmd_valid = 0;
    repeat (2) tick();
    PRESET = 1;
    tick(); PRESET = 0;
    @(negedge PCLK);
    chk("mr_psel", PSEL, 0); chk("mr_penable", PENABLE, 0); chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_paddr", PADDR, 0); chk("mr_cmd_ready", cmd_ready, 1);

    // Randomized traffic
    gen_cmd(); cmd_valid = 1;
    for (int i = 0; i < N; i++) begin
      k = 0;
      accepted = 0;
      while (!accepted && k < 20) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        tick(); k++;
      end
      if (!accepted) chk("accept_bound", 0, 1);
      cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom_range(0, 1));
      rst_plan = ($urandom_range(0, 19) == 0);
      preload = 1'($urandom_range(0, 1));
      k = 0;
      while (m_busy && k < 60) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        if (rst_plan && phase(cyc) == 2) begin
          PRESET = 1; rst_plan = 0;
        end else if (preload && !cmd_valid && phase(cyc) == 3) begin
          gen_cmd(); cmd_valid = 1;
        end
        tick(); PRESET = 0; k++;
      end
      if (m_busy) begin
        chk("complete_bound", 0, 1);
        cmd_valid = 0; PRESET = 1; tick(); PRESET = 0;
      end
      if (!cmd_valid) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin rsp_ready = 1'($urandom_range(0, 1)); tick(); end
        gen_cmd(); cmd_valid = 1;
      end
    end
    cmd_valid = 0;

    k = 0;
    while (!h_done && k < 5000) begin tick(); k++; end
    if (!h_done) chk("hang_done_bound", 0, 1);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
